pdm_decimator: RTL
==================

# pdm_decimator

Converts a 1-bit pulse-density audio stream (external PDM microphone, or loop-back of our PWM DAC pin) into unsigned PCM samples at the synth sample rate. It is the receive-side counterpart of the DAC: a third-order CIC decimator, decimating by 2^DECIM_LOG2, with saturation and output scaling to BITDEPTH. It sits between an input pin and any sample consumer (mixer, level meter, record buffer) in the audio subsystem.

## Interface
- BITDEPTH, 14, width of output PCM sample (unsigned, same format as the DAC input)
- DECIM_LOG2, 8, log2 of decimation ratio R; 8 gives 8 MHz / 256 = 31,250 Hz
- clk  input  1  system clock, 8 MHz nominal; the only clock
- rst  input  1  asynchronous, active-high reset
- pdm_in  input  1  raw 1-bit stream from the pin, asynchronous to clk
- pcm  output  BITDEPTH  decimated unsigned sample, held between updates
- sample_valid  output  1  one-clk pulse when pcm takes a new value

Constraint: DECIM_LOG2 ≥ 2 and BITDEPTH ≤ 3*DECIM_LOG2.

## Operation
- Internal width W = 3*DECIM_LOG2 + 1; all integrator and comb registers are W bits, arithmetic modulo 2^W (wrap is intentional and correct for CIC).
- Input path: pdm_in → 2-flop synchronizer → bit x (0 or 1, zero-extended to W).
- Integrators, every clk: i1 <= i1 + x; i2 <= i2 + i1; i3 <= i3 + i2 (old values on the right).
- Decimation counter dcnt, DECIM_LOG2 bits, free-running from 0 after reset; strobe when dcnt == all ones.
- On strobe cycle, comb chain combinational and registered:
  - c1 = i3 − d1; c2 = c1 − d2; c3 = c2 − d3; then d1 <= i3, d2 <= c1, d3 <= c2.
  - Saturate: s = (c3 ≥ 2^(3*DECIM_LOG2)) ? 2^(3*DECIM_LOG2) − 1 : c3. Only the all-ones input reaches 2^(3*DECIM_LOG2).
  - pcm <= s >> (3*DECIM_LOG2 − BITDEPTH) (truncation, no rounding).
- Priming: 2-bit counter prime counts strobes up to 3, saturates. While prime < 3 at the strobe, pcm and delay lines update but sample_valid stays low. First sample_valid is on the 4th strobe after reset.
- Gain: DC input density p maps to pcm = floor(p * 2^BITDEPTH), clamped to 2^BITDEPTH − 1.

## Timing
- Reset values: pcm = 0, sample_valid = 0; i1..i3, d1..d3, dcnt, prime, synchronizer flops all 0.
- Reset mid-operation: all state clears immediately (async); priming restarts; no sample_valid until the 4th strobe after rst deasserts.
- Strobe period exactly 2^DECIM_LOG2 clk; first strobe in cycle 2^DECIM_LOG2 − 1 after reset release (cycle 0 = first rising edge with rst low).
- pcm and sample_valid change on the clk edge ending the strobe cycle; sample_valid high for exactly one clk, then low for 2^DECIM_LOG2 − 1 clk.
- pdm_in to integrator latency: 2 clk (synchronizer) + 1 clk.
- Step response: a density change fully settles in pcm within 3 decimated samples (after the sample in progress).
- No backpressure: consumer must capture pcm on sample_valid or read the held value before the next pulse.

## Test plan
- Reset, then pdm_in = 0 constantly for 10 sample periods → pcm stays 0; sample_valid first pulses at clk 4*256 − 1 after reset release, then every 256 clk.
- pdm_in = 1 constantly for 100 sample periods → after settling pcm = 16383 every sample (saturation and integrator wrap both exercised); never wraps to 0.
- pdm_in alternating 1,0 each clk → settled pcm = 8192 exactly; pattern 1,0,0,0 → 4096; pattern 1,1,1,0 → 12288.
- Step: density 0 → 1/2 at an arbitrary clk → pcm monotonic non-decreasing and equals 8192 by the 4th valid sample after the step.
- rst pulsed for 3 clk mid-run with pdm_in = 1 → pcm and sample_valid go 0 asynchronously; no sample_valid for 1023 clk after release; next valid pcm = 16383.
- DECIM_LOG2 = 4, BITDEPTH = 12 instance: sample_valid period 16 clk; alternating input → pcm = 2048.

Source files
------------

// File: rtl/pdm_decimator.sv
// Third-order CIC decimator: 1-bit PDM in, unsigned BITDEPTH PCM out every 2^DECIM_LOG2 clk.
// Output registered on the strobe edge; 2-clk input synchronizer; no backpressure, pcm held between pulses.
module pdm_decimator #(
  parameter int BITDEPTH   = 14,
  parameter int DECIM_LOG2 = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pdm_in,
  output logic [BITDEPTH-1:0] pcm,
  output logic                sample_valid
);

  localparam int GW    = 3 * DECIM_LOG2;
  localparam int W     = GW + 1;
  localparam int SHIFT = GW - BITDEPTH;

  localparam logic [W-1:0] SAT_MAX = {1'b0, {GW{1'b1}}};

  logic [1:0]            sync_q;
  logic [W-1:0]          x;
  logic [W-1:0]          i1, i2, i3;
  logic [W-1:0]          d1, d2, d3;
  logic [W-1:0]          c1, c2, c3;
  logic [W-1:0]          s;
  logic [DECIM_LOG2-1:0] dcnt;
  logic                  strobe;
  logic [1:0]            prime;

  assign x      = {{(W-1){1'b0}}, sync_q[1]};
  assign strobe = &dcnt;

  // Comb stage works on the integrator value present in the strobe cycle.
  assign c1 = i3 - d1;
  assign c2 = c1 - d2;
  assign c3 = c2 - d3;

  // Only a full-scale (all-ones) input sets the top bit; clamp it one below.
  assign s = c3[GW] ? SAT_MAX : c3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      i1     <= '0;
      i2     <= '0;
      i3     <= '0;
      dcnt   <= '0;
    end else begin
      sync_q <= {sync_q[0], pdm_in};
      i1     <= i1 + x;
      i2     <= i2 + i1;
      i3     <= i3 + i2;
      dcnt   <= dcnt + DECIM_LOG2'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d1           <= '0;
      d2           <= '0;
      d3           <= '0;
      prime        <= '0;
      pcm          <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (strobe) begin
        d1  <= i3;
        d2  <= c1;
        d3  <= c2;
        pcm <= BITDEPTH'(s >> SHIFT);
        // The first three strobes only fill the comb delay lines.
        sample_valid <= (prime == 2'd3);
        if (prime != 2'd3) begin
          prime <= prime + 2'd1;
        end
      end
    end
  end

endmodule
